// File: rtl/fuzz_vector_sequencer.sv
// fuzz_vector_sequencer
// Drives LFSR-generated stimulus vectors into a device under test, waits a
// programmable number of settle cycles, then folds the response into a MISR
// signature. Two netlists fed by identically configured sequencers produce
// identical signatures, which makes this usable for equivalence/bug hunting.
//
// Optional feature: define FUZZ_SEQ_COMPARE_EN to add an expected_sig input
// and a registered mismatch output, evaluated when a run completes.

module fuzz_vector_sequencer #(
  parameter int                STIM_W    = 52,
  parameter int                Y_W       = 241,
  parameter int                SIG_W     = 32,
  parameter logic [63:0]       LFSR_POLY = 64'h000000000000001B,
  parameter logic [SIG_W-1:0]  MISR_POLY = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]  SIG_INIT  = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [63:0]       seed,
  input  logic [15:0]       num_vectors,
  input  logic [3:0]        settle_cycles,
  input  logic [Y_W-1:0]    dut_y,
`ifdef FUZZ_SEQ_COMPARE_EN
  input  logic [SIG_W-1:0]  expected_sig,
  output logic              mismatch,
`endif
  output logic [STIM_W-1:0] stim_vec,
  output logic              stim_valid,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [15:0]       vec_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  // The response is split into SIG_W-bit slices; the last one is zero-padded.
  localparam int NUM_SLICES = (Y_W + SIG_W - 1) / SIG_W;
  localparam int PAD_W      = NUM_SLICES * SIG_W;

  state_t              state_reg, state_next;
  logic [63:0]         lfsr_reg;
  logic [STIM_W-1:0]   stim_vec_reg;
  logic [SIG_W-1:0]    sig_reg;
  logic [15:0]         vec_count_reg;
  logic [15:0]         num_lat_reg;
  logic [3:0]          settle_lat_reg;
  logic [3:0]          settle_cnt_reg;

  logic                start_go;
  logic [15:0]         vec_count_inc;
  logic [63:0]         lfsr_step;
  logic [SIG_W-1:0]    sig_step;
  logic [PAD_W-1:0]    y_pad;
  logic [SIG_W-1:0]    y_slice [NUM_SLICES];
  logic [SIG_W-1:0]    fold;

  // A start is only taken in IDLE, and a simultaneous abort suppresses it.
  assign start_go      = (state_reg == IDLE) && start && !abort;
  assign vec_count_inc = vec_count_reg + 16'd1;

  // Galois LFSR: shift left, fold the taps back in when the MSB falls out.
  assign lfsr_step = {lfsr_reg[62:0], 1'b0} ^ (lfsr_reg[63] ? LFSR_POLY : 64'h0);

  assign y_pad = PAD_W'(dut_y);

  generate
    for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
      assign y_slice[gi] = y_pad[gi*SIG_W +: SIG_W];
    end
  endgenerate

  // XOR-compact all response slices into one signature-wide word.
  always_comb begin
    fold = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      fold = fold ^ y_slice[i];
    end
  end

  assign sig_step = {sig_reg[SIG_W-2:0], 1'b0}
                  ^ (sig_reg[SIG_W-1] ? MISR_POLY : '0)
                  ^ fold;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; abort returns to IDLE from every active state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_go) begin
          state_next = (num_vectors == 16'd0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          state_next = (settle_lat_reg != 4'd0) ? SETTLE : CAPTURE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (settle_cnt_reg == 4'd1) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          state_next = (vec_count_inc == num_lat_reg) ? DONE : LOAD;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    busy       = (state_reg != IDLE);
    stim_valid = (state_reg == SETTLE) || (state_reg == CAPTURE);
    done       = (state_reg == DONE);
  end

  // Datapath: run configuration latch, LFSR, stimulus, settle timer, MISR.
  // An aborted cycle leaves every value as it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg       <= 64'h1;
      stim_vec_reg   <= '0;
      sig_reg        <= SIG_INIT;
      vec_count_reg  <= 16'd0;
      num_lat_reg    <= 16'd0;
      settle_lat_reg <= 4'd0;
      settle_cnt_reg <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_go) begin
            num_lat_reg    <= num_vectors;
            settle_lat_reg <= settle_cycles;
            lfsr_reg       <= (seed == 64'h0) ? 64'h1 : seed;
            sig_reg        <= SIG_INIT;
            vec_count_reg  <= 16'd0;
          end
        end
        LOAD: begin
          if (!abort) begin
            stim_vec_reg   <= lfsr_reg[STIM_W-1:0];
            lfsr_reg       <= lfsr_step;
            settle_cnt_reg <= settle_lat_reg;
          end
        end
        SETTLE: begin
          if (!abort) begin
            settle_cnt_reg <= settle_cnt_reg - 4'd1;
          end
        end
        CAPTURE: begin
          if (!abort) begin
            sig_reg       <= sig_step;
            vec_count_reg <= vec_count_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FUZZ_SEQ_COMPARE_EN
  logic mismatch_reg;

  // Compare result is taken at completion and cleared when a new run starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_reg <= 1'b0;
    end else if (start_go) begin
      mismatch_reg <= 1'b0;
    end else if (state_reg == DONE) begin
      mismatch_reg <= (sig_reg != expected_sig);
    end
  end

  assign mismatch = mismatch_reg;
`endif

  assign stim_vec  = stim_vec_reg;
  assign signature = sig_reg;
  assign vec_count = vec_count_reg;

endmodule

// File: tb/tb_fuzz_vector_sequencer.sv
// Self-checking bench for fuzz_vector_sequencer: a reference model fills
// expected-stimulus and expected-result queues when each run is launched, and
// they are popped as the sequencer presents vectors and completes runs.

module tb_fuzz_vector_sequencer;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [63:0]   seed;
  logic [15:0]   num_vectors;
  logic [3:0]    settle_cycles;
  logic [240:0]  dut_y;
  logic [51:0]   stim_vec;
  logic          stim_valid;
  logic          busy;
  logic          done;
  logic [31:0]   signature;
  logic [15:0]   vec_count;
`ifdef FUZZ_SEQ_COMPARE_EN
  logic [31:0]   expected_sig;
  logic          mismatch;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Response generator controls.
  logic          y_mode;      // 0: constant y_const, 1: function of stim_vec
  logic [240:0]  y_const;
  logic          flip_en;
  int            flip_k;
  int            flip_bit;

  logic [51:0]   exp_stim_q [$];
  logic [31:0]   exp_sig_q  [$];
  logic [15:0]   exp_cnt_q  [$];

  fuzz_vector_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .seed          (seed),
    .num_vectors   (num_vectors),
    .settle_cycles (settle_cycles),
    .dut_y         (dut_y),
`ifdef FUZZ_SEQ_COMPARE_EN
    .expected_sig  (expected_sig),
    .mismatch      (mismatch),
`endif
    .stim_vec      (stim_vec),
    .stim_valid    (stim_valid),
    .busy          (busy),
    .done          (done),
    .signature     (signature),
    .vec_count     (vec_count)
  );

  always #5 clk = ~clk;

  // Deterministic pseudo-netlist: each output bit taps one stimulus bit.
  function automatic logic [240:0] fn_y(input logic [51:0] st);
    logic [240:0] y;
    for (int i = 0; i < 241; i++) begin
      y[i] = st[(i * 7) % 52] ^ ((i % 3) == 0);
    end
    return y;
  endfunction

  function automatic logic [63:0] m_lfsr(input logic [63:0] x);
    logic [63:0] r;
    r = x << 1;
    if (x[63]) r = r ^ 64'h1B;
    return r;
  endfunction

  function automatic logic [31:0] m_fold(input logic [240:0] y);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < 241; i++) begin
      f[i % 32] = f[i % 32] ^ y[i];
    end
    return f;
  endfunction

  function automatic logic [31:0] m_misr(input logic [31:0] s, input logic [31:0] f);
    logic [31:0] r;
    r = s << 1;
    if (s[31]) r = r ^ 32'h04C11DB7;
    return r ^ f;
  endfunction

  // Expected response for vector index v with stimulus st.
  function automatic logic [240:0] y_of(input logic [51:0] st, input int v);
    logic [240:0] y;
    if (y_mode) begin
      y = fn_y(st);
      if (flip_en && v == flip_k) y[flip_bit] = ~y[flip_bit];
    end else begin
      y = y_const;
    end
    return y;
  endfunction

  // Response presented to the sequencer.
  always_comb begin
    dut_y = y_const;
    if (y_mode) begin
      dut_y = fn_y(stim_vec);
      if (flip_en && stim_valid && (int'(vec_count) == flip_k)) begin
        dut_y[flip_bit] = ~dut_y[flip_bit];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ne(input string tag, input logic [63:0] a, input logic [63:0] b);
    n_checks++;
    assert (a !== b) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected_different_from=%0h", tag, a, b);
    end
  endtask

  // Launch one run, scoreboard stimulus and result; abort_at>=0 aborts in the
  // first valid cycle of that vector index.
  task automatic run(input logic [63:0] sd, input logic [15:0] n, input logic [3:0] s,
                     input int abort_at, output logic [31:0] fsig);
    logic [63:0]  l;
    logic [31:0]  sg;
    int           nv, ns, k, valid_cycles;
    logic         prev, fin;
    l  = (sd == 64'h0) ? 64'h1 : sd;
    sg = 32'hFFFFFFFF;
    nv = (abort_at >= 0) ? abort_at : int'(n);
    ns = (abort_at >= 0) ? abort_at + 1 : int'(n);
    for (int v = 0; v < ns; v++) begin
      exp_stim_q.push_back(l[51:0]);
      if (v < nv) sg = m_misr(sg, m_fold(y_of(l[51:0], v)));
      l = m_lfsr(l);
    end
    exp_sig_q.push_back(sg);
    exp_cnt_q.push_back(16'(nv));

    seed = sd; num_vectors = n; settle_cycles = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Later changes to the run configuration must be ignored.
    seed = 64'hDEAD_BEEF_0000_0000; num_vectors = 16'hFFFF; settle_cycles = 4'hF;
    chk("sig_at_start", signature, 32'hFFFFFFFF);
    chk("cnt_at_start", vec_count, 0);
`ifdef FUZZ_SEQ_COMPARE_EN
    chk("mismatch_cleared", mismatch, 0);
`endif
    k = 0; prev = 1'b0; valid_cycles = 0; fin = 1'b0;
    while (!fin && k < 5000) begin
      if (stim_valid) valid_cycles++;
      if (stim_valid && !prev) begin
        if (exp_stim_q.size() > 0) chk("stim_vec", stim_vec, exp_stim_q.pop_front());
        else chk("stim_unexpected", stim_valid, 0);
        if (abort_at >= 0 && int'(vec_count) == abort_at) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          chk("abort_busy", busy, 0);
          chk("abort_valid", stim_valid, 0);
          chk("abort_done", done, 0);
          chk("abort_sig", signature, exp_sig_q.pop_front());
          chk("abort_cnt", vec_count, exp_cnt_q.pop_front());
          @(negedge clk);
          chk("abort_no_done", done, 0);
          fin = 1'b1;
        end
      end
      if (!fin && done) begin
        chk("done_latency", k, int'(n) * (int'(s) + 2));
        chk("valid_cycles", valid_cycles, int'(n) * (int'(s) + 1));
        chk("done_busy", busy, 1);
        chk("final_sig", signature, exp_sig_q.pop_front());
        chk("final_cnt", vec_count, exp_cnt_q.pop_front());
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
        fin = 1'b1;
      end
      if (!fin) begin
        prev = stim_valid;
        @(negedge clk);
        k++;
      end
    end
    chk("run_completed", fin, 1);
    fsig = signature;
  endtask

  initial begin
    logic [31:0] s1, s2, s3, sx;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed = '0; num_vectors = '0;
    settle_cycles = '0; y_mode = 1'b0; y_const = '0; flip_en = 1'b0;
    flip_k = 0; flip_bit = 0;
`ifdef FUZZ_SEQ_COMPARE_EN
    expected_sig = '0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_stim", stim_vec, 0);
    chk("rst_valid", stim_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sig", signature, 32'hFFFFFFFF);
    chk("rst_cnt", vec_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single vector, no settle, zero response
    run(64'h0, 16'd1, 4'd0, -1, sx);
    chk("tp1_sig", sx, 32'hFB3EE249);
    $display("run tp1 seed=0 n=1 s=0 sig=%08h", sx);

    // 2: two vectors with settle time
    run(64'h0, 16'd2, 4'd3, -1, sx);
    $display("run tp2 seed=0 n=2 s=3 sig=%08h", sx);

    // 3: zero-length run
    run(64'h1234, 16'd0, 4'd5, -1, sx);
    chk("tp3_sig", sx, 32'hFFFFFFFF);
    $display("run tp3 n=0 sig=%08h", sx);

    // Non-zero constant response with a high seed exercising LFSR feedback
    y_const = {8{32'hA5C3_0F96}};
    run(64'hF123_4567_89AB_CDEF, 16'd6, 4'd1, -1, sx);
    $display("run const seed=f123456789abcdef n=6 s=1 sig=%08h", sx);
    y_const = '0;

    // 4: abort in SETTLE of the fifth vector, then restart
    run(64'h5A5A, 16'd100, 4'd2, 4, sx);
    $display("run tp4 abort at vector 4 sig=%08h cnt=%0d", sx, vec_count);
    run(64'h5A5A, 16'd3, 4'd0, -1, sx);
    $display("run tp4 restart sig=%08h", sx);

    // abort and start together in IDLE: no run
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", busy, 0);
    $display("idle start+abort busy=%0b", busy);

    // 5: response as a function of stimulus; repeatability and sensitivity
    y_mode = 1'b1;
    run(64'h0BAD_CAFE_1234_5678, 16'd8, 4'd1, -1, s1);
`ifdef FUZZ_SEQ_COMPARE_EN
    expected_sig = s1;
`endif
    run(64'h0BAD_CAFE_1234_5678, 16'd8, 4'd1, -1, s2);
    chk("repeat_sig", s2, s1);
`ifdef FUZZ_SEQ_COMPARE_EN
    chk("mismatch_same", mismatch, 0);
`endif
    flip_en = 1'b1; flip_k = 5; flip_bit = 200;
    run(64'h0BAD_CAFE_1234_5678, 16'd8, 4'd1, -1, s3);
    chk_ne("flip_sig_differs", s3, s1);
`ifdef FUZZ_SEQ_COMPARE_EN
    chk("mismatch_flip", mismatch, 1);
`endif
    flip_en = 1'b0;
    $display("run tp5 sig_a=%08h sig_b=%08h sig_flip=%08h", s1, s2, s3);

    // 6: asynchronous reset in CAPTURE, start held during reset
    seed = 64'h77; num_vectors = 16'd3; settle_cycles = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);   // LOAD -> SETTLE -> CAPTURE
    chk("tp6_in_capture", stim_valid, 1);
    rst_n = 1'b0; start = 1'b1;
    #1;
    chk("tp6_stim", stim_vec, 0);
    chk("tp6_valid", stim_valid, 0);
    chk("tp6_busy", busy, 0);
    chk("tp6_done", done, 0);
    chk("tp6_sig", signature, 32'hFFFFFFFF);
    chk("tp6_cnt", vec_count, 0);
    repeat (2) @(negedge clk);
    chk("tp6_held_busy", busy, 0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("tp6_after_release", busy, 0);
    $display("reset mid-capture busy=%0b sig=%08h", busy, signature);
    y_mode = 1'b0;
    run(64'h0, 16'd1, 4'd0, -1, sx);
    chk("tp6_rerun_sig", sx, 32'hFB3EE249);
    $display("run after reset sig=%08h", sx);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fuzz_vector_sequencer.md
Name: fuzz_vector_sequencer

Overview:
- Sequences randomized stimulus into a generated combinational/sequential DUT (52-bit packed input bundle, 241-bit output y).
- Samples the DUT response after a programmable settle time and compacts every response into a MISR signature.
- Sits between the regression harness (start/seed/count) and the DUT under equivalence/bug hunting.
- Two netlists driven by identical sequencers must produce identical signatures.

Parameters:
STIM_W, 52, width of packed DUT input bundle {wire4,wire3,wire2,wire1,wire0}
Y_W, 241, width of DUT output y
SIG_W, 32, signature width
LFSR_POLY, 64'h000000000000001B, Galois feedback taps of 64-bit stimulus LFSR
MISR_POLY, 32'h04C11DB7, MISR feedback taps
SIG_INIT, 32'hFFFFFFFF, signature value loaded at start

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  launch a run; sampled only in IDLE
abort  in  1  terminate the run; honoured in any non-IDLE state
seed  in  64  LFSR seed; zero is replaced by 64'h1
num_vectors  in  16  vectors per run
settle_cycles  in  4  wait cycles between drive and capture
dut_y  in  Y_W  DUT response
stim_vec  out  STIM_W  registered DUT input bundle
stim_valid  out  1  stim_vec is held stable for the current vector
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at run completion
signature  out  SIG_W  running/final MISR value
vec_count  out  16  vectors captured so far

Behaviour:
- Reset values: state=IDLE; stim_vec=0; stim_valid=0; busy=0; done=0; signature=SIG_INIT; vec_count=0; LFSR=64'h1.
- Reset asserted mid-run returns all of the above to reset values immediately.
- States: IDLE, LOAD, SETTLE, CAPTURE, DONE.
- IDLE, start=1:
  - Latch num_vectors and settle_cycles (later changes are ignored until next run).
  - LFSR<=seed (or 1 if seed==0); signature<=SIG_INIT; vec_count<=0.
  - Next state: LOAD, or DONE if num_vectors==0.
- start in any other state is ignored.
- LOAD (1 cycle):
  - stim_vec<=LFSR[STIM_W-1:0].
  - LFSR advances: shift left 1; if the old MSB==1, XOR LFSR_POLY.
  - Next state: SETTLE if latched settle_cycles>0, else CAPTURE.
- SETTLE: lasts exactly settle_cycles cycles (down-counter), then CAPTURE.
- stim_valid: 1 in SETTLE and CAPTURE, 0 otherwise.
- CAPTURE (1 cycle), using the dut_y value present that cycle:
  - fold = XOR of dut_y split into SIG_W-bit slices, with the last slice zero-padded.
  - signature<={signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1]?MISR_POLY:0) ^ fold.
  - vec_count++.
  - Next state: DONE if the new count==num_vectors, else LOAD.
- DONE (1 cycle): done=1, then IDLE. signature and vec_count hold until the next start.
- Latency: start sampled at edge T → done high in the cycle after edge T+n*(s+2), where n=num_vectors and s=settle_cycles.
- abort: next state IDLE; no done pulse; signature and vec_count keep their partial values; stim_valid deasserts.
- abort and start together in IDLE: abort wins and start is ignored.
- vec_count saturates implicitly because num_vectors≤65535; no wrap occurs in a run.

Optional Feature:
FUZZ_SEQ_COMPARE_EN:
- Defined: adds input expected_sig[SIG_W] and output mismatch (1-bit, registered).
- mismatch is updated in DONE to (signature!=expected_sig) and holds until the next start, which clears it.
- mismatch is cleared by reset.
- Undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
1. seed=0, num_vectors=1, settle=0, dut_y=0, start at edge T → stim_vec=52'h1 from T+1; done pulse in the cycle after T+2; signature=32'hFB3EE249; vec_count=1.
2. seed=0, num_vectors=2, settle=3 → second stim_vec=52'h2; stim_valid high 4 cycles per vector; done in the cycle after T+10.
3. num_vectors=0 → DONE one cycle after start; signature=32'hFFFFFFFF; vec_count=0; stim_valid never asserted.
4. num_vectors=100, abort in SETTLE of vector 5 → IDLE next cycle, no done, vec_count=4; a following start resets signature to SIG_INIT.
5. Two runs with the same seed and dut_y driven as a fixed function of stim_vec → identical final signatures. Flip one dut_y bit in one vector → signatures differ. With FUZZ_SEQ_COMPARE_EN, mismatch=1 only on the flipped run.
6. rst_n low mid-CAPTURE → all outputs return to reset values asynchronously; start held during reset causes no run until after release.
